// File: rtl/flo_dispatch.sv
// Command dispatcher: decodes sequencer commands onto a shared channel bus,
// tracks per-channel FIFO credits, stalls when a target is full and halts on errors.
module flo_dispatch #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     cmd_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  output logic [15:0]     data_o,
  output logic [6:0]      delay_o,
  output logic [N_CH-1:0] valid_o,
  output logic [N_CH-1:0] direct_o,
  input  logic [N_CH-1:0] stb_i,
  input  logic [N_CH-1:0] err_i,
  input  logic            halt_on_err_i,
  input  logic            resume_i,
  output logic            bad_cmd_o,
  output logic [N_CH-1:0] err_sticky_o,
  output logic            halted_o,
  output logic [15:0]     stall_cnt_o
);

  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, STALL, HALT} state_t;

  state_t            state_q, state_d;
  logic              hold_v_q, hold_v_d;
  logic              hold_dir_q, hold_dir_d;
  logic [CHW-1:0]    hold_ch_q, hold_ch_d;
  logic [15:0]       hold_data_q, hold_data_d;
  logic [6:0]        hold_delay_q, hold_delay_d;
  logic [CW-1:0]     credit_q [N_CH];
  logic [CW-1:0]     credit_d [N_CH];
  logic [N_CH-1:0]   dsh1_q, dsh1_d, dsh2_q, dsh2_d;
  logic [15:0]       data_q, data_d;
  logic [6:0]        delay_q, delay_d;
  logic [N_CH-1:0]   valid_q, valid_d, direct_q, direct_d;
  logic              bad_cmd_q, bad_cmd_d;
  logic [N_CH-1:0]   err_sticky_q, err_sticky_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              halted, issue_now, accept, bad, err_halt, can_issue_d;
  logic [N_CH-1:0]   ret, take;

  assign halted      = (state_q == HALT);
  assign issue_now   = hold_v_q && !halted && (hold_dir_q || (credit_q[hold_ch_q] != '0));
  assign cmd_ready_o = rst_n && !halted && (!hold_v_q || issue_now);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign bad         = (cmd_i[31:28] != 4'h0) || ({1'b0, cmd_i[27:24]} >= 5'(N_CH));
  assign err_halt    = halt_on_err_i && ((accept && bad) || (|err_i));

  // Direct-write strobes come back from the buffer two cycles later and carry no credit
  assign ret  = stb_i & ~dsh2_q;
  assign take = (issue_now && !hold_dir_q) ? (N_CH'(1) << hold_ch_q) : '0;

  always_comb begin
    state_d      = state_q;
    hold_v_d     = hold_v_q;
    hold_dir_d   = hold_dir_q;
    hold_ch_d    = hold_ch_q;
    hold_data_d  = hold_data_q;
    hold_delay_d = hold_delay_q;
    credit_d     = credit_q;
    dsh1_d       = direct_q;
    dsh2_d       = dsh1_q;
    data_d       = data_q;
    delay_d      = delay_q;
    valid_d      = '0;
    direct_d     = '0;
    bad_cmd_d    = 1'b0;
    err_sticky_d = (resume_i ? '0 : err_sticky_q) | err_i;
    stall_cnt_d  = stall_cnt_q;
    can_issue_d  = 1'b0;

    if (issue_now) begin
      data_d   = hold_data_q;
      delay_d  = hold_delay_q;
      hold_v_d = 1'b0;
      if (hold_dir_q) direct_d[hold_ch_q] = 1'b1;
      else            valid_d[hold_ch_q]  = 1'b1;
    end

    if (accept) begin
      if (bad) begin
        bad_cmd_d = 1'b1;
      end else begin
        hold_v_d     = 1'b1;
        hold_dir_d   = cmd_i[23];
        hold_ch_d    = cmd_i[24 +: CHW];
        hold_delay_d = cmd_i[22:16];
        hold_data_d  = cmd_i[15:0];
      end
    end

    // Simultaneous issue and return on one channel leaves the credit unchanged
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (take[c] && !ret[c])
        credit_d[c] = CW'(credit_q[c] - CW'(1));
      else if (ret[c] && !take[c] && (credit_q[c] != CW'(DEPTH)))
        credit_d[c] = CW'(credit_q[c] + CW'(1));
    end

    if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;

    can_issue_d = hold_dir_d || (credit_d[hold_ch_d] != '0);

    if (err_halt)
      state_d = HALT;
    else if (halted)
      state_d = resume_i ? (hold_v_q ? ISSUE : IDLE) : HALT;
    else if (!hold_v_d)
      state_d = IDLE;
    else
      state_d = can_issue_d ? ISSUE : STALL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_v_q     <= 1'b0;
      hold_dir_q   <= 1'b0;
      hold_ch_q    <= '0;
      hold_data_q  <= '0;
      hold_delay_q <= '0;
      for (int unsigned c = 0; c < N_CH; c++) credit_q[c] <= CW'(DEPTH);
      dsh1_q       <= '0;
      dsh2_q       <= '0;
      data_q       <= '0;
      delay_q      <= '0;
      valid_q      <= '0;
      direct_q     <= '0;
      bad_cmd_q    <= 1'b0;
      err_sticky_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      hold_v_q     <= hold_v_d;
      hold_dir_q   <= hold_dir_d;
      hold_ch_q    <= hold_ch_d;
      hold_data_q  <= hold_data_d;
      hold_delay_q <= hold_delay_d;
      credit_q     <= credit_d;
      dsh1_q       <= dsh1_d;
      dsh2_q       <= dsh2_d;
      data_q       <= data_d;
      delay_q      <= delay_d;
      valid_q      <= valid_d;
      direct_q     <= direct_d;
      bad_cmd_q    <= bad_cmd_d;
      err_sticky_q <= err_sticky_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign data_o       = data_q;
  assign delay_o      = delay_q;
  assign valid_o      = valid_q;
  assign direct_o     = direct_q;
  assign bad_cmd_o    = bad_cmd_q;
  assign err_sticky_o = err_sticky_q;
  assign halted_o     = halted;
  assign stall_cnt_o  = stall_cnt_q;

endmodule
